// File: rtl/jtag_debug_cmd_queue.sv
// jtag_debug_cmd_queue
// System-clock side command receiver for the debug slave.
// Update-DR / update-IR levels arrive from the TCK domain. Each level is
// synchronised into clk, and an armed rising-edge detector runs on the
// result. Every honoured update-DR captures {ir_in, sr} into a show-ahead
// FIFO that the consumer drains with a valid/ready handshake.
//
// Ports
//   clk, reset_n         system clock, synchronous active-low reset
//   vs_udr, vs_uir       update-DR / update-IR levels (asynchronous)
//   ir_in, sr            IR and scanned data, stable while vs_udr is high
//   cmd_valid/cmd_ready  head handshake
//   cmd_ir, cmd_data     head entry (all-zero when the FIFO is empty)
//   cmd_action           one-hot decode of cmd_ir, qualified by cmd_valid
//   cmd_go               top bit of cmd_data (take_action / take_no_action)
//   ir_update            one-cycle pulse per honoured vs_uir rise
//   fifo_level           number of entries held, 0..FIFO_DEPTH
//   overflow             sticky flag: a scan was dropped on a full FIFO
//   overflow_clr         clears overflow (a new drop in the same cycle wins)
module jtag_debug_cmd_queue #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   vs_udr,
  input  logic                   vs_uir,
  input  logic [IR_WIDTH-1:0]    ir_in,
  input  logic [SR_WIDTH-1:0]    sr,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [IR_WIDTH-1:0]    cmd_ir,
  output logic [SR_WIDTH-1:0]    cmd_data,
  output logic [2**IR_WIDTH-1:0] cmd_action,
  output logic                   cmd_go,
  output logic                   ir_update,
  output logic [LEVEL_W-1:0]     fifo_level,
  output logic                   overflow,
  input  logic                   overflow_clr
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = IR_WIDTH + SR_WIDTH;
  localparam int ACT_W   = 2**IR_WIDTH;

  // Synchronisers and edge detection
  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] uir_sync;
  // A 1 shifts along 'fill' after reset. Once it reaches the last stage,
  // the last synchroniser flop holds a real sample of the input rather
  // than its reset value. Only real low samples may arm a detector, so a
  // level held high through reset release never produces an event.
  logic [SYNC_STAGES-1:0] fill;
  logic udr_prev, uir_prev;
  logic udr_arm, uir_arm;
  logic udr_last, uir_last, fill_last;
  logic udr_evt, uir_evt;

  assign udr_last  = udr_sync[SYNC_STAGES-1];
  assign uir_last  = uir_sync[SYNC_STAGES-1];
  assign fill_last = fill[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      udr_sync <= '0;
      uir_sync <= '0;
      fill     <= '0;
      udr_prev <= 1'b0;
      uir_prev <= 1'b0;
      udr_arm  <= 1'b0;
      uir_arm  <= 1'b0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
      udr_prev <= udr_last;
      uir_prev <= uir_last;
      udr_arm  <= udr_arm | (fill_last & ~udr_last);
      uir_arm  <= uir_arm | (fill_last & ~uir_last);
    end
  end

  assign udr_evt = udr_arm & udr_last & ~udr_prev;
  assign uir_evt = uir_arm & uir_last & ~uir_prev;

  always_ff @(posedge clk) begin
    if (!reset_n) ir_update <= 1'b0;
    else          ir_update <= uir_evt;
  end

  // Command FIFO
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               full, pop, push, drop;
  logic [ENTRY_W-1:0] head;

  assign full = (fifo_level == LEVEL_W'(FIFO_DEPTH));
  assign pop  = cmd_valid & cmd_ready;
  // A pop in the same cycle frees the slot that a push into a full FIFO needs.
  assign push = udr_evt & (~full | pop);
  assign drop = udr_evt & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ir_in, sr};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_level <= fifo_level + LEVEL_W'(1);
      else if (pop && !push) fifo_level <= fifo_level - LEVEL_W'(1);
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  // Show-ahead head, masked to zero while empty
  assign cmd_valid = (fifo_level != '0);
  assign head      = cmd_valid ? mem[rd_ptr] : '0;
  assign cmd_ir    = head[ENTRY_W-1:SR_WIDTH];
  assign cmd_data  = head[SR_WIDTH-1:0];
  assign cmd_go    = cmd_data[SR_WIDTH-1];

  always_comb begin
    cmd_action = '0;
    for (int k = 0; k < ACT_W; k++) begin
      cmd_action[k] = cmd_valid && (cmd_ir == IR_WIDTH'(k));
    end
  end

endmodule

// File: tb/tb_jtag_debug_cmd_queue.sv
module tb_jtag_debug_cmd_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  // instance 1: default parameters
  logic        vs_udr, vs_uir, cmd_ready, overflow_clr;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_valid, cmd_go, ir_update, overflow;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic [3:0]  cmd_action;
  logic [2:0]  fifo_level;
  // instance 2: SYNC_STAGES=3, FIFO_DEPTH=8, IR_WIDTH=3, SR_WIDTH=64
  logic        vs_udr2, vs_uir2, cmd_ready2, overflow_clr2;
  logic [2:0]  ir_in2;
  logic [63:0] sr2;
  logic        cmd_valid2, cmd_go2, ir_update2, overflow2;
  logic [2:0]  cmd_ir2;
  logic [63:0] cmd_data2;
  logic [7:0]  cmd_action2;
  logic [3:0]  fifo_level2;

  jtag_debug_cmd_queue dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_action(cmd_action),
    .cmd_go(cmd_go), .ir_update(ir_update), .fifo_level(fifo_level),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  jtag_debug_cmd_queue #(
    .SR_WIDTH(64), .IR_WIDTH(3), .SYNC_STAGES(3), .FIFO_DEPTH(8)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr2), .vs_uir(vs_uir2),
    .ir_in(ir_in2), .sr(sr2), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_ir(cmd_ir2), .cmd_data(cmd_data2), .cmd_action(cmd_action2),
    .cmd_go(cmd_go2), .ir_update(ir_update2), .fifo_level(fifo_level2),
    .overflow(overflow2), .overflow_clr(overflow_clr2)
  );

  int tests = 0;
  int fails = 0;
  logic [39:0] sb[$];   // expected {ir, data} entries of instance 1
  logic        exp_ovf;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete DR scan on instance 1 with cmd_ready low; the model
  // queues the entry, or expects a drop when four are already held.
  task automatic scan(input logic [1:0] ir, input logic [37:0] data);
    ir_in  = ir;
    sr     = data;
    vs_udr = 1'b1;
    if (sb.size() < 4) sb.push_back({ir, data});
    else               exp_ovf = 1'b1;
    repeat (3) tick();
    vs_udr = 1'b0;
    repeat (4) tick();
  endtask

  task automatic pop_one(input string tag);
    logic [39:0] e;
    int n;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check({tag, " valid"}, 64'(cmd_valid), 64'(1));
    e = '0;
    if (sb.size() != 0) e = sb.pop_front();
    check({tag, " ir"}, 64'(cmd_ir), 64'(e[39:38]));
    check({tag, " data"}, 64'(cmd_data), 64'(e[37:0]));
    check({tag, " go"}, 64'(cmd_go), 64'(e[37]));
    check({tag, " action"}, 64'(cmd_action), 64'(4'b0001 << e[39:38]));
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  initial begin
    logic [39:0] e;
    reset_n = 1'b0;
    vs_udr = 1'b1; vs_uir = 1'b0; ir_in = '0; sr = '0;
    cmd_ready = 1'b0; overflow_clr = 1'b0;
    vs_udr2 = 1'b0; vs_uir2 = 1'b0; ir_in2 = '0; sr2 = '0;
    cmd_ready2 = 1'b0; overflow_clr2 = 1'b0;
    exp_ovf = 1'b0;

    // reset state, vs_udr held high across reset release
    repeat (3) tick();
    check("rst level", 64'(fifo_level), 64'(0));
    check("rst valid", 64'(cmd_valid), 64'(0));
    check("rst ovf", 64'(overflow), 64'(0));
    check("rst ir_update", 64'(ir_update), 64'(0));
    check("rst data", 64'(cmd_data), 64'(0));
    check("rst action", 64'(cmd_action), 64'(0));
    reset_n = 1'b1;
    repeat (8) tick();
    check("hold_high level", 64'(fifo_level), 64'(0));
    check("hold_high valid", 64'(cmd_valid), 64'(0));
    vs_udr = 1'b0;
    repeat (4) tick();
    scan(2'b10, 38'h03_0000_0055);
    check("rearm level", 64'(fifo_level), 64'(1));
    pop_one("rearm pop");
    check("rearm empty", 64'(fifo_level), 64'(0));

    // latency and head decode
    ir_in = 2'b01; sr = 38'h20_0000_1234; vs_udr = 1'b1;
    tick();
    check("lat N valid", 64'(cmd_valid), 64'(0));
    tick();
    check("lat N+1 valid", 64'(cmd_valid), 64'(0));
    tick();
    check("lat N+2 valid", 64'(cmd_valid), 64'(1));
    check("lat action", 64'(cmd_action), 64'(4'b0010));
    check("lat go", 64'(cmd_go), 64'(1));
    check("lat data", 64'(cmd_data), 64'(38'h20_0000_1234));
    check("lat ir", 64'(cmd_ir), 64'(2'b01));
    vs_udr = 1'b0;
    repeat (4) tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("popped valid", 64'(cmd_valid), 64'(0));
    check("popped data", 64'(cmd_data), 64'(0));
    check("popped ir", 64'(cmd_ir), 64'(0));
    check("popped action", 64'(cmd_action), 64'(0));
    check("popped go", 64'(cmd_go), 64'(0));
    check("popped level", 64'(fifo_level), 64'(0));

    // five scans into a depth-4 FIFO
    for (int i = 1; i <= 5; i++) scan(2'(i), 38'(i));
    check("ovf level", 64'(fifo_level), 64'(4));
    check("ovf flag", 64'(overflow), 64'(exp_ovf));
    for (int i = 0; i < 4; i++) pop_one("ovf drain");
    check("ovf sticky", 64'(overflow), 64'(1));
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    exp_ovf = 1'b0;
    check("ovf cleared", 64'(overflow), 64'(exp_ovf));

    // full FIFO, pop and push land on the same edge
    for (int i = 0; i < 4; i++) scan(2'(i), 38'(16 + i));
    check("full level", 64'(fifo_level), 64'(4));
    ir_in = 2'b11; sr = 38'h99; vs_udr = 1'b1;
    tick();
    tick();
    cmd_ready = 1'b1;
    e = sb.pop_front();
    check("simul head", 64'(cmd_data), 64'(e[37:0]));
    sb.push_back({2'b11, 38'h99});
    tick();
    cmd_ready = 1'b0;
    check("simul level", 64'(fifo_level), 64'(4));
    check("simul ovf", 64'(overflow), 64'(0));
    tick();
    vs_udr = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) pop_one("simul drain");

    // pointer wrap over twelve sequential scans
    for (int i = 0; i < 12; i++) begin
      scan(2'(i), 38'(256 + i));
      pop_one("wrap");
    end
    check("wrap level", 64'(fifo_level), 64'(0));

    // reset flushes a partially full FIFO with overflow set
    for (int i = 0; i < 5; i++) scan(2'(i), 38'(512 + i));
    pop_one("flush pre");
    check("flush pre level", 64'(fifo_level), 64'(3));
    check("flush pre ovf", 64'(overflow), 64'(1));
    reset_n = 1'b0;
    tick();
    check("flush level", 64'(fifo_level), 64'(0));
    check("flush valid", 64'(cmd_valid), 64'(0));
    check("flush ovf", 64'(overflow), 64'(0));
    reset_n = 1'b1;
    sb.delete();
    exp_ovf = 1'b0;
    repeat (5) tick();

    // ir_update latency, FIFO untouched
    scan(2'b01, 38'h77);
    vs_uir = 1'b1;
    tick();
    check("uir N", 64'(ir_update), 64'(0));
    tick();
    check("uir N+1", 64'(ir_update), 64'(0));
    tick();
    check("uir N+2", 64'(ir_update), 64'(1));
    tick();
    check("uir N+3", 64'(ir_update), 64'(0));
    check("uir level", 64'(fifo_level), 64'(1));
    vs_uir = 1'b0;
    pop_one("uir pop");

    // wide configuration: three sync stages, 3-bit IR
    ir_in2 = 3'd5; sr2 = 64'h8000_0000_0000_ABCD; vs_udr2 = 1'b1;
    tick();
    check("w N valid", 64'(cmd_valid2), 64'(0));
    tick();
    check("w N+1 valid", 64'(cmd_valid2), 64'(0));
    tick();
    check("w N+2 valid", 64'(cmd_valid2), 64'(0));
    tick();
    check("w N+3 valid", 64'(cmd_valid2), 64'(1));
    check("w action", 64'(cmd_action2), 64'(8'b0010_0000));
    check("w go", 64'(cmd_go2), 64'(1));
    check("w data", cmd_data2, 64'h8000_0000_0000_ABCD);
    vs_udr2 = 1'b0; vs_uir2 = 1'b1;
    tick();
    check("w uir N", 64'(ir_update2), 64'(0));
    tick();
    check("w uir N+1", 64'(ir_update2), 64'(0));
    tick();
    check("w uir N+2", 64'(ir_update2), 64'(0));
    tick();
    check("w uir N+3", 64'(ir_update2), 64'(1));
    tick();
    check("w uir N+4", 64'(ir_update2), 64'(0));
    check("w level", 64'(fifo_level2), 64'(1));
    vs_uir2 = 1'b0;
    cmd_ready2 = 1'b1;
    tick();
    cmd_ready2 = 1'b0;
    check("w drained", 64'(cmd_valid2), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtag_debug_cmd_queue.md
Name: jtag_debug_cmd_queue

Overview:
Sysclk-side command receiver for the debug slave. It takes update-DR and update-IR strobes and the shift-register/IR contents produced in the TCK domain, synchronises the strobes into clk, and captures each completed DR scan with its IR. Captured scans go into a parametrised show-ahead command FIFO with a valid/ready handshake. It decodes the IR to a one-hot action vector and reports overflow, so back-to-back scans are never silently merged.

Parameters:
SR_WIDTH, 38, width of scanned data register (sr / cmd_data)
IR_WIDTH, 2, width of instruction register; action vector is 2**IR_WIDTH bits
SYNC_STAGES, 2, synchroniser flops on vs_udr / vs_uir (>=2)
FIFO_DEPTH, 4, command entries; power of 2, >=2
LEVEL_W, log2(FIFO_DEPTH)+1, width of fifo_level (derived, not overridden)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
vs_udr  in  1  update-DR level from TCK domain, asynchronous to clk
vs_uir  in  1  update-IR level from TCK domain, asynchronous to clk
ir_in  in  IR_WIDTH  current IR; stable while vs_udr high
sr  in  SR_WIDTH  scanned data; stable while vs_udr high
cmd_valid  out  1  FIFO head valid
cmd_ready  in  1  consumer accepts head
cmd_ir  out  IR_WIDTH  head IR
cmd_data  out  SR_WIDTH  head data
cmd_action  out  2**IR_WIDTH  one-hot decode of cmd_ir
cmd_go  out  1  cmd_data[SR_WIDTH-1] (take_action vs take_no_action)
ir_update  out  1  one-cycle pulse per vs_uir rising edge
fifo_level  out  LEVEL_W  entries held, 0..FIFO_DEPTH
overflow  out  1  sticky: scan dropped because FIFO was full
overflow_clr  in  1  clears overflow

Behaviour:
- Reset (reset_n low at a clk edge): sync chains, edge registers, arm flags, pointers, fifo_level and overflow are all 0. cmd_valid=0, ir_update=0. The FIFO is flushed mid-operation; in-flight entries are lost.
- Sync: vs_udr and vs_uir each pass through SYNC_STAGES flops, then one "previous" flop. rise = sync_last & ~prev.
- Arming: each edge detector has an arm flag, cleared on reset and set when its synchronised level is seen low. A rise is honoured only when armed. A level held high through reset release produces no event.
- Latency (SYNC_STAGES=2): vs_udr high sampled at edge N. Push occurs at edge N+2. cmd_valid is high from edge N+2. In general, push occurs SYNC_STAGES edges after first sampling.
- Push: on an honoured udr rise, {ir_in, sr} is written at the tail. This happens if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Overflow: if the FIFO is full with no pop, the entry is dropped, the FIFO is unchanged and overflow is set next edge. If set and overflow_clr coincide, set wins.
- Pop: cmd_valid & cmd_ready at an edge advances the head. cmd_ready while empty is ignored.
- Simultaneous push and pop: fifo_level is unchanged. When empty, push+ready in the same cycle pops nothing, because cmd_valid was 0.
- Show-ahead head: cmd_ir, cmd_data, cmd_action and cmd_go are driven from the head entry when cmd_valid=1, and are all-zero when empty.
- cmd_action[k] = (cmd_ir == k) & cmd_valid.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. fifo_level counts separately, saturating by construction at FIFO_DEPTH.
- ir_update: pulse one cycle after an honoured uir rise is detected, with the same latency as the push. It is independent of FIFO state.
- vs_udr pulses narrower than one clk period are not guaranteed to be captured (protocol guarantee from TCK side).

Test Plan:
- Reset, vs_udr high through reset release -> no push; fifo_level=0, cmd_valid=0. Drop vs_udr, raise again -> one entry.
- IR=2'b01, sr=38'h20_0000_1234, pulse vs_udr, cmd_ready=0 -> cmd_valid high 2 edges after sampling; cmd_action=4'b0010, cmd_go=1, cmd_data=38'h20_0000_1234. Then assert cmd_ready for 1 cycle -> cmd_valid=0, all head outputs 0.
- Five scans (sr=1..5) with cmd_ready=0, depth 4 -> fifo_level=4, overflow=1. Drain -> data 1,2,3,4 in order. overflow_clr -> overflow=0.
- FIFO full, cmd_ready held 1 while a 5th scan arrives -> pop and push same cycle; fifo_level stays 4, overflow stays 0. Wrap verified by 12 sequential scans drained in order.
- Assert reset_n=0 with 3 entries queued -> next edge: fifo_level=0, cmd_valid=0, overflow=0.
- vs_uir pulse -> ir_update high exactly one cycle, 2 edges after sampling; fifo_level unchanged. Repeat with SYNC_STAGES=3, FIFO_DEPTH=8, IR_WIDTH=3, SR_WIDTH=64: latency is 3 edges, cmd_action is 8 bits one-hot.
